uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised 16550-class receive path: oversampled start-bit qualification, 5–8 data bits, optional odd/even/stick parity, and error tagging (parity, framing, break). A DEPTH-entry receive FIFO with trigger levels and overrun detection sits behind the deserializer. Sits beside the transmitter under the UART top level and is fed by the register block's baud tick. The register block owns LCR/FCR decode and LSR assembly.

Parameters:
OS, 16, baud_tick pulses per bit; even, ≥4
DEPTH, 16, FIFO entries; power of 2, ≥4
CW, $clog2(DEPTH)+1, width of rx_count (derived)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
baud_tick  in  1  one-cycle pulse at OS× bit rate
rx  in  1  serial input, asynchronous, idle high
wls  in  2  word length: 00=5, 01=6, 10=7, 11=8 bits
pen  in  1  parity enable
eps  in  1  even parity select
sp  in  1  stick parity
trig_lvl  in  2  00=1, 01=DEPTH/4, 10=DEPTH/2, 11=DEPTH-2
rd  in  1  pop head entry (one pulse per entry)
fifo_clr  in  1  synchronous FIFO flush
ovr_clr  in  1  clear sticky overrun flag
rdata  out  8  head data; upper unused bits zero
rstat  out  3  head status {bi, fe, pe}
data_ready  out  1  FIFO not empty
overrun  out  1  sticky overrun flag
fifo_err  out  1  at least one stored entry has a nonzero rstat
rx_count  out  CW  entries held, 0..DEPTH
rx_trig  out  1  rx_count ≥ trigger level
rx_busy  out  1  deserializer not in IDLE

Behaviour:
- Reset (async, rst=1): FSM=IDLE; FIFO empty; all outputs 0; synchroniser flops preset to 1.
- rx passes through a 2-flop synchroniser; all decisions use the synchronised value rxs.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT. The tick counter counts baud_tick only.
- IDLE: when rxs=0 → START. Clear tick counter. Latch wls/pen/eps/sp for the whole frame; mid-frame config changes take effect next frame.
- START: on the OS/2-th tick, sample rxs. If rxs=1 it is a false start → IDLE with no entry. If rxs=0 → DATA.
- DATA: sample every OS ticks, LSB first, for 5+wls bits. Then → PARITY if pen, else → STOP.
- PARITY: sample after OS ticks. Expected bit is:
  - sp=1: ~eps
  - sp=0, eps=1: XOR of data
  - sp=0, eps=0: ~XOR of data
  - pe = sampled ≠ expected.
- STOP: sample after OS ticks. fe = (rxs==0). bi = fe & all data bits 0 & (parity bit 0 or !pen).
- Push timing: the entry is pushed the cycle after the stop sample. Next state is BRK_WAIT if rxs=0, else IDLE.
- BRK_WAIT: stay until rxs=1, then → IDLE. No further entries are produced while the line stays low.
- FIFO is show-ahead: rdata/rstat reflect the head combinationally from storage. rd pops when not empty; rd on empty is ignored (no underflow, pointers unchanged).
- Push while full without a same-cycle rd: character discarded, overrun set to 1, FIFO contents unchanged.
- Push and rd in the same cycle while full: both are accepted, no overrun, count stays DEPTH.
- Push and rd in the same cycle while empty: push accepted, rd ignored, count becomes 1.
- fifo_clr: pointers and count zeroed next cycle, fifo_err cleared. A concurrent push is dropped. A frame in progress continues and pushes normally afterwards.
- overrun: set on a dropped push, cleared by ovr_clr; set wins if both occur in the same cycle.
- fifo_err: driven by an error-entry counter that increments on push with nonzero status and decrements on pop of such an entry. fifo_err = counter≠0.
- Pointers: $clog2(DEPTH) bits, natural wrap-around. rx_count is a registered counter.
- Reset mid-frame: the partial character is lost and the FIFO is emptied.

Decomposition:
- Package uart_pkg:
  - rx state enum
  - wls encoding constants
  - trigger-level encoding
  - rx entry struct {bi, fe, pe, data[7:0]} (11 bits)
- Sub-module uart_sync_fifo (WIDTH, DEPTH): storage, pointers, count, full/empty, show-ahead read.
- Deserializer FSM, parity logic, error counter and trigger compare live in uart_rx_fifo.

Test Plan:
- OS=16, baud_tick every 4 clk, wls=11, pen=0: send 0xA5 → one entry, rdata=0xA5, rstat=000, data_ready=1; entry appears 1 clk after the stop mid-sample.
- wls=00, pen=1, eps=0: send 5'h10 with parity bit 1 (bad) → rdata=0x10, rstat=001, fifo_err=1. Then rd → fifo_err=0, data_ready=0.
- Hold rx=0 for 3 frame times then release → exactly one entry, rdata=0x00, rstat=110. rx_busy stays 1 until rx returns high.
- DEPTH=16: send 17 chars 0x01..0x11 with no rd → rx_count=16, overrun=1, rdata=0x01; popping all 16 yields 0x01..0x10. ovr_clr → overrun=0.
- rx low pulse of 4 ticks only (false start) → no entry, rx_busy returns to 0, next valid 0x3C is received correctly.
- trig_lvl=10: 7 chars → rx_trig=0, 8th → rx_trig=1. Then fifo_clr → rx_count=0, rx_trig=0. Assert rst mid-frame → all outputs 0, the next frame is received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and encodings for the UART receive path: FSM states, word-length
// and trigger-level codes, and the layout of one receive FIFO entry.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BRK_WAIT
  } rx_state_t;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  localparam logic [1:0] TRIG_ONE       = 2'b00;
  localparam logic [1:0] TRIG_QUARTER   = 2'b01;
  localparam logic [1:0] TRIG_HALF      = 2'b10;
  localparam logic [1:0] TRIG_NEAR_FULL = 2'b11;

  typedef struct packed {
    logic       bi;
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_entry_t;

  // Index of the last data bit for a given word-length code.
  function automatic logic [2:0] last_data_bit(input logic [1:0] wls);
    case (wls)
      WLS_5:   return 3'd4;
      WLS_6:   return 3'd5;
      WLS_7:   return 3'd6;
      WLS_8:   return 3'd7;
      default: return 3'd7;
    endcase
  endfunction

  function automatic int trig_level(input logic [1:0] sel, input int depth);
    case (sel)
      TRIG_ONE:       return 1;
      TRIG_QUARTER:   return depth / 4;
      TRIG_HALF:      return depth / 2;
      TRIG_NEAR_FULL: return depth - 2;
      default:        return depth - 2;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with registered occupancy count and a synchronous
// flush. A write while full is accepted only when a read frees a slot that cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             wr_ok,
  output logic             rd_ok,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_ok = wr & ~clr & (~full | rd);
  assign rd_ok = rd & ~clr & ~empty;
  assign rdata = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) rptr <= rptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 16550-style receive path: oversampled deserializer with parity/framing/break
// tagging, feeding a show-ahead receive FIFO with trigger and overrun flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int OS    = 16,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          baud_tick,
  input  logic          rx,
  input  logic [1:0]    wls,
  input  logic          pen,
  input  logic          eps,
  input  logic          sp,
  input  logic [1:0]    trig_lvl,
  input  logic          rd,
  input  logic          fifo_clr,
  input  logic          ovr_clr,
  output logic [7:0]    rdata,
  output logic [2:0]    rstat,
  output logic          data_ready,
  output logic          overrun,
  output logic          fifo_err,
  output logic [CW-1:0] rx_count,
  output logic          rx_trig,
  output logic          rx_busy
);

  localparam int TW = $clog2(OS);
  localparam logic [TW-1:0] TICK_MID  = TW'(OS / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OS - 1);

  logic          rx_meta;
  logic          rxs;
  rx_state_t     state;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    last_bit;
  logic [7:0]    shreg;
  logic          f_pen;
  logic          f_eps;
  logic          f_sp;
  logic          par_bit;
  logic          pe_q;
  logic          par_expect;
  logic          push;
  rx_entry_t     push_entry;
  rx_entry_t     head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push_ok;
  logic          pop_ok;
  logic          push_err;
  logic          pop_err;
  logic [CW-1:0] err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) {rx_meta, rxs} <= 2'b11;
    else     {rx_meta, rxs} <= {rx, rx_meta};
  end

  // Unused upper bits of shreg stay zero, so the full-width XOR is the data XOR.
  assign par_expect = f_sp ? ~f_eps : (f_eps ? ^shreg : ~^shreg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RX_IDLE;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      last_bit   <= '0;
      shreg      <= '0;
      f_pen      <= 1'b0;
      f_eps      <= 1'b0;
      f_sp       <= 1'b0;
      par_bit    <= 1'b0;
      pe_q       <= 1'b0;
      push       <= 1'b0;
      push_entry <= '0;
    end else begin
      push <= 1'b0;
      case (state)
        RX_IDLE: begin
          tick_cnt <= '0;
          bit_idx  <= '0;
          shreg    <= '0;
          par_bit  <= 1'b0;
          pe_q     <= 1'b0;
          if (!rxs) begin
            state    <= RX_START;
            last_bit <= last_data_bit(wls);
            f_pen    <= pen;
            f_eps    <= eps;
            f_sp     <= sp;
          end
        end
        RX_START: if (baud_tick) begin
          if (tick_cnt == TICK_MID) begin
            tick_cnt <= '0;
            state    <= rxs ? RX_IDLE : RX_DATA;
          end else tick_cnt <= tick_cnt + TW'(1);
        end
        RX_DATA: if (baud_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt       <= '0;
            shreg[bit_idx] <= rxs;
            if (bit_idx == last_bit) state <= f_pen ? RX_PARITY : RX_STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else tick_cnt <= tick_cnt + TW'(1);
        end
        RX_PARITY: if (baud_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            par_bit  <= rxs;
            pe_q     <= (rxs != par_expect);
            state    <= RX_STOP;
          end else tick_cnt <= tick_cnt + TW'(1);
        end
        RX_STOP: if (baud_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt   <= '0;
            push       <= 1'b1;
            push_entry <= '{bi:   ~rxs & (shreg == 8'h00) & (~par_bit | ~f_pen),
                            fe:   ~rxs,
                            pe:   pe_q,
                            data: shreg};
            state      <= rxs ? RX_IDLE : RX_BRK_WAIT;
          end else tick_cnt <= tick_cnt + TW'(1);
        end
        RX_BRK_WAIT: if (rxs) state <= RX_IDLE;
        default: state <= RX_IDLE;
      endcase
    end
  end

  uart_sync_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (fifo_clr),
    .wr    (push),
    .wdata (push_entry),
    .rd    (rd),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .wr_ok (push_ok),
    .rd_ok (pop_ok),
    .count (rx_count)
  );

  assign push_err = push_ok & (push_entry.bi | push_entry.fe | push_entry.pe);
  assign pop_err  = pop_ok & (head.bi | head.fe | head.pe);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       err_cnt <= '0;
    else if (fifo_clr)             err_cnt <= '0;
    else if (push_err && !pop_err) err_cnt <= err_cnt + CW'(1);
    else if (pop_err && !push_err) err_cnt <= err_cnt - CW'(1);
  end

  // A flushed push is dropped silently; only a full FIFO raises overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        overrun <= 1'b0;
    else if (push && fifo_full && !rd && !fifo_clr) overrun <= 1'b1;
    else if (ovr_clr)                               overrun <= 1'b0;
  end

  assign rdata      = head.data;
  assign rstat      = {head.bi, head.fe, head.pe};
  assign data_ready = ~fifo_empty;
  assign fifo_err   = (err_cnt != '0);
  assign rx_trig    = (rx_count >= CW'(trig_level(trig_lvl, DEPTH)));
  assign rx_busy    = (state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames from a reference model, expected FIFO
// entries queued at send time and compared by a monitor that drains the FIFO.
module tb_uart_rx_fifo;

  localparam int OS       = 16;
  localparam int DEPTH    = 16;
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int TPB      = 4;
  localparam int BIT_CLKS = OS * TPB;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          baud_tick = 1'b0;
  logic          rx        = 1'b1;
  logic [1:0]    wls       = 2'b11;
  logic          pen       = 1'b0;
  logic          eps       = 1'b0;
  logic          sp        = 1'b0;
  logic [1:0]    trig_lvl  = 2'b00;
  logic          rd        = 1'b0;
  logic          fifo_clr  = 1'b0;
  logic          ovr_clr   = 1'b0;
  logic [7:0]    rdata;
  logic [2:0]    rstat;
  logic          data_ready;
  logic          overrun;
  logic          fifo_err;
  logic [CW-1:0] rx_count;
  logic          rx_trig;
  logic          rx_busy;

  // Expected entries {bi, fe, pe, data[7:0]} in arrival order.
  logic [10:0] exp_q[$];
  logic        drain_en  = 1'b0;
  logic        model_ovr = 1'b0;
  int          checks    = 0;
  int          errors    = 0;

  uart_rx_fifo #(.OS(OS), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .rx         (rx),
    .wls        (wls),
    .pen        (pen),
    .eps        (eps),
    .sp         (sp),
    .trig_lvl   (trig_lvl),
    .rd         (rd),
    .fifo_clr   (fifo_clr),
    .ovr_clr    (ovr_clr),
    .rdata      (rdata),
    .rstat      (rstat),
    .data_ready (data_ready),
    .overrun    (overrun),
    .fifo_err   (fifo_err),
    .rx_count   (rx_count),
    .rx_trig    (rx_trig),
    .rx_busy    (rx_busy)
  );

  // ---------------- clock / reset / baud ----------------
  always #5 clk = ~clk;

  initial forever begin
    repeat (TPB - 1) @(negedge clk);
    baud_tick = 1'b1;
    @(negedge clk);
    baud_tick = 1'b0;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Parity bit a correct transmitter would send for the given data.
  function automatic logic parity_bit(input logic [7:0] d, input logic even, input logic stick);
    int ones;
    ones = $countones(d);
    if (stick) return ~even;
    if (even) return (ones % 2) == 1;
    return (ones % 2) == 0;
  endfunction

  function automatic int trig_threshold(input logic [1:0] sel);
    case (sel)
      2'b00:   return 1;
      2'b01:   return DEPTH / 4;
      2'b10:   return DEPTH / 2;
      default: return DEPTH - 2;
    endcase
  endfunction

  function automatic int model_err_entries();
    int n;
    n = 0;
    foreach (exp_q[i]) if (exp_q[i][10:8] != 3'b000) n++;
    return n;
  endfunction

  task automatic expect_entry(input logic [10:0] e);
    if (drain_en || exp_q.size() < DEPTH) exp_q.push_back(e);
    else model_ovr = 1'b1;
  endtask

  // ---------------- driver ----------------
  task automatic send_char(input logic [7:0] c, input logic bad, input logic scramble,
                           input int stop_clks);
    int         nb;
    logic [7:0] d;
    logic       p;
    logic       l_pen;
    nb    = 5 + int'(wls);
    l_pen = pen;
    d     = c;
    for (int i = nb; i < 8; i++) d[i] = 1'b0;
    p = parity_bit(d, eps, sp) ^ bad;
    expect_entry({1'b0, 1'b0, l_pen & bad, d});
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    if (scramble) begin
      wls = 2'($urandom_range(0, 3));
      pen = 1'($urandom_range(0, 1));
      eps = 1'($urandom_range(0, 1));
      sp  = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < nb; i++) begin
      rx = d[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    if (l_pen) begin
      rx = p;
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = 1'b1;
    repeat (stop_clks) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((data_ready || exp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_done"}, 32'(n < 200), 32'd1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always begin : monitor
    logic [10:0] e;
    @(negedge clk);
    rd = 1'b0;
    if (drain_en && data_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_entry: got data 0x%0h stat 0x%0h, none expected", rdata, rstat);
      end else begin
        e = exp_q.pop_front();
        check("mon_rdata", rdata, e[7:0]);
        check("mon_rstat", rstat, e[10:8]);
      end
      rd = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_data_ready", data_ready, 0);
    check("rst_rx_count", rx_count, 0);
    check("rst_overrun", overrun, 0);
    check("rst_fifo_err", fifo_err, 0);
    check("rst_rx_trig", rx_trig, 0);
    check("rst_rx_busy", rx_busy, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rstat", rstat, 0);
    rst = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);

    // 8N1 0xA5, entry must land during the stop bit near its middle.
    wls = 2'b11; pen = 1'b0; trig_lvl = 2'b00; drain_en = 1'b0;
    send_char(8'hA5, 1'b0, 1'b0, 0);
    check("a5_not_before_stop", data_ready, 0);
    n = 0;
    while (!data_ready && n < BIT_CLKS) begin
      @(negedge clk);
      n++;
    end
    check("a5_push_in_stop_mid", 32'(n >= 24 && n <= 48), 32'd1);
    check("a5_rdata", rdata, 8'hA5);
    check("a5_rstat", rstat, 0);
    check("a5_count", rx_count, 1);
    check("a5_trig_one", rx_trig, 1);
    check("a5_fifo_err", fifo_err, 0);
    repeat (BIT_CLKS - n + 8) @(negedge clk);
    drain_en = 1'b1;
    wait_drain("a5");

    // 5-bit odd parity with a wrong parity bit.
    wls = 2'b00; pen = 1'b1; eps = 1'b0; sp = 1'b0; drain_en = 1'b0;
    send_char(8'h10, 1'b1, 1'b0, BIT_CLKS);
    check("pe_rdata", rdata, 8'h10);
    check("pe_rstat", rstat, 3'b001);
    check("pe_fifo_err", fifo_err, 1);
    drain_en = 1'b1;
    wait_drain("pe");
    check("pe_fifo_err_after_pop", fifo_err, 0);
    check("pe_data_ready_after_pop", data_ready, 0);

    // Break: line low for three frame times yields exactly one entry.
    wls = 2'b11; pen = 1'b0; drain_en = 1'b0;
    expect_entry(11'b110_0000_0000);
    rx = 1'b0;
    repeat (3 * 10 * BIT_CLKS) @(negedge clk);
    check("brk_busy_held", rx_busy, 1);
    check("brk_one_entry", rx_count, 1);
    rx = 1'b1;
    n = 0;
    while (rx_busy && n < 16) begin
      @(negedge clk);
      n++;
    end
    check("brk_busy_released", rx_busy, 0);
    check("brk_rdata", rdata, 0);
    check("brk_rstat", rstat, 3'b110);
    check("brk_fifo_err", fifo_err, 1);
    repeat (BIT_CLKS) @(negedge clk);
    drain_en = 1'b1;
    wait_drain("brk");

    // Overrun: 17 characters into a 16-entry FIFO.
    drain_en = 1'b0;
    for (int i = 1; i <= 17; i++) send_char(8'(i), 1'b0, 1'b0, BIT_CLKS + 4);
    check("ovr_count_full", rx_count, DEPTH);
    check("ovr_flag", overrun, model_ovr);
    check("ovr_head", rdata, 8'h01);
    drain_en = 1'b1;
    wait_drain("ovr");
    check("ovr_sticky", overrun, 1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    model_ovr = 1'b0;
    check("ovr_cleared", overrun, model_ovr);

    // False start: 4-tick low glitch.
    rx = 1'b0;
    repeat (4 * TPB) @(negedge clk);
    check("fs_busy_during", rx_busy, 1);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    check("fs_busy_after", rx_busy, 0);
    check("fs_no_entry", rx_count, 0);
    send_char(8'h3C, 1'b0, 1'b0, BIT_CLKS);
    wait_drain("fs");

    // Trigger level DEPTH/2, then flush.
    trig_lvl = 2'b10; pen = 1'b1; eps = 1'b1; sp = 1'b0; drain_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_char(8'($urandom_range(0, 255)), 1'(i == 2), 1'b0, BIT_CLKS);
      check("trig_count", rx_count, exp_q.size());
      check("trig_flag", rx_trig, 32'(exp_q.size() >= trig_threshold(trig_lvl)));
    end
    check("trig_fifo_err", fifo_err, 32'(model_err_entries() != 0));
    fifo_clr = 1'b1;
    @(negedge clk);
    fifo_clr = 1'b0;
    exp_q.delete();
    check("clr_count", rx_count, 0);
    check("clr_trig", rx_trig, 0);
    check("clr_fifo_err", fifo_err, 0);
    check("clr_data_ready", data_ready, 0);

    // Random frames with mid-frame configuration changes.
    drain_en = 1'b1; trig_lvl = 2'b00;
    for (int i = 0; i < 12; i++) begin
      send_char(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                BIT_CLKS + int'($urandom_range(0, 40)));
    end
    wait_drain("rand");
    check("rand_fifo_err", fifo_err, 0);

    // Reset in the middle of a frame with entries buffered.
    wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0; trig_lvl = 2'b10; drain_en = 1'b0;
    send_char(8'h11, 1'b0, 1'b0, BIT_CLKS);
    send_char(8'h22, 1'b0, 1'b0, BIT_CLKS);
    rx = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    rst = 1'b1;
    #1;
    check("mrst_data_ready", data_ready, 0);
    check("mrst_rx_count", rx_count, 0);
    check("mrst_rx_busy", rx_busy, 0);
    check("mrst_rdata", rdata, 0);
    check("mrst_rstat", rstat, 0);
    check("mrst_overrun", overrun, 0);
    check("mrst_fifo_err", fifo_err, 0);
    check("mrst_rx_trig", rx_trig, 0);
    exp_q.delete();
    model_ovr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drain_en = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    send_char(8'h5A, 1'b0, 1'b0, BIT_CLKS);
    wait_drain("mrst");
    check("final_overrun", overrun, model_ovr);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
